// File: rtl/shift_unit_arbiter.sv
// Round-robin arbiter that shares one LVL-stage barrel shifter among NREQ requesters.
// Define SHIFT_ARB_ROTATE_EN to build the rotate-right stage; otherwise op 11 passes through and flags rsp_err.
module shift_unit_arbiter #(
  parameter int N    = 32,
  parameter int LVL  = 5,
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*N-1:0]     req_data,
  input  logic [NREQ*LVL-1:0]   req_amt,
  input  logic [NREQ*2-1:0]     req_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [N-1:0]          rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_err
);

  logic [IDW-1:0]      ptr;
  logic                accept;
  logic                xfer;
  logic [IDW-1:0]      cand;
  logic                vld_p0;
  logic [IDW-1:0]      win_id_p0;
  logic [N-1:0]        opnd_p0;
  logic [LVL-1:0]      amt_p0;
  logic [1:0]          op_p0;
  logic signed [N-1:0] shf_p0;
  logic                err_p0;

  assign accept = !rsp_valid || rsp_ready;

  // Stage p0: round-robin search starting at ptr, then operand select and shift.
  always_comb begin
    vld_p0    = 1'b0;
    win_id_p0 = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (!vld_p0 && req_valid[cand]) begin
        vld_p0    = 1'b1;
        win_id_p0 = cand;
      end
    end
  end

  assign xfer = rst_n && accept && vld_p0;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[win_id_p0] = 1'b1;
  end

  assign opnd_p0 = req_data[int'(win_id_p0)*N +: N];
  assign amt_p0  = req_amt[int'(win_id_p0)*LVL +: LVL];
  assign op_p0   = req_op[int'(win_id_p0)*2 +: 2];

  // Each amount bit selects one power-of-two stage; arithmetic fill comes from the signed MSB.
  always_comb begin
    shf_p0 = opnd_p0;
    err_p0 = 1'b0;
`ifndef SHIFT_ARB_ROTATE_EN
    if (op_p0 == 2'b11) err_p0 = 1'b1;
`endif
    for (int l = 0; l < LVL; l++) begin
      if (amt_p0[l]) begin
        case (op_p0)
          2'b00:   shf_p0 = shf_p0 >> (1 << l);
          2'b01:   shf_p0 = shf_p0 >>> (1 << l);
          2'b10:   shf_p0 = shf_p0 << (1 << l);
`ifdef SHIFT_ARB_ROTATE_EN
          default: shf_p0 = (shf_p0 >> (1 << l)) | (shf_p0 << (N - (1 << l)));
`else
          default: shf_p0 = shf_p0;
`endif
        endcase
      end
    end
  end

  // Stage p1: single result slot; drain and refill may happen on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_err   <= 1'b0;
      ptr       <= '0;
    end else if (xfer) begin
      rsp_valid <= 1'b1;
      rsp_data  <= shf_p0;
      rsp_id    <= win_id_p0;
      rsp_err   <= err_p0;
      ptr       <= (win_id_p0 == IDW'(NREQ - 1)) ? '0 : win_id_p0 + 1'b1;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Directed-vector bench for shift_unit_arbiter (N=32, LVL=5, NREQ=4).
// Rotate expectations follow SHIFT_ARB_ROTATE_EN as defined for the build.
module tb_shift_unit_arbiter;

  localparam int N = 32;
  localparam int LVL = 5;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_data;
  logic [NREQ*LVL-1:0] req_amt;
  logic [NREQ*2-1:0] req_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [N-1:0]      rsp_data;
  logic [1:0]        rsp_id;
  logic              rsp_err;

  int checks = 0;
  int errors = 0;

  shift_unit_arbiter #(.N(N), .LVL(LVL), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_amt(req_amt), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] d, input logic [4:0] a, input logic [1:0] o);
    req_data[i*N +: N] = d;
    req_amt[i*LVL +: LVL] = a;
    req_op[i*2 +: 2] = o;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h1111_1111 * (i + 1), 5'd3, 2'b10);
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready_pre got=%b exp=0000", req_ready); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=00000000", rsp_data); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", rsp_id); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", rsp_err); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    req_valid = '0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_asr();
    rsp_ready = 1'b1;
    set_req(0, 32'h8000_0001, 5'd4, 2'b01);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL asr_ready got=%b exp=0001", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL asr_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_data !== 32'hF800_0000) begin errors++; $display("FAIL asr_data got=%h exp=f8000000", rsp_data); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL asr_id got=%0d exp=0", rsp_id); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL asr_err got=%b exp=0", rsp_err); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL asr_drain got=%b exp=0", rsp_valid); end
  endtask

  // Ends with slot holding id 1 and all requesters still valid (ptr = 2).
  task automatic test_round_robin();
    logic [31:0] dv [4];
    logic [1:0] exp_id [6];
    exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    dv = '{32'hA0A0_0000, 32'hB1B1_0001, 32'hC2C2_0002, 32'hD3D3_0003};
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, dv[i], 5'd0, 2'(i % 3));
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 6; k++) begin
      checks++; if (req_ready !== (4'b0001 << exp_id[k])) begin errors++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, req_ready, 4'b0001 << exp_id[k]); end
      tick();
      checks++; if (rsp_id !== exp_id[k] || rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_id[%0d] got=%0d/v%b exp=%0d/v1", k, rsp_id, rsp_valid, exp_id[k]); end
      checks++; if (rsp_data !== dv[exp_id[k]]) begin errors++; $display("FAIL rr_data[%0d] got=%h exp=%h", k, rsp_data, dv[exp_id[k]]); end
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=0000", c, req_ready); end
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 32'hB1B1_0001) begin
        errors++; $display("FAIL bp_hold[%0d] got=v%b id%0d %h exp=v1 id1 b1b10001", c, rsp_valid, rsp_id, rsp_data);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_refill_ready got=%b exp=0100", req_ready); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 32'hC2C2_0002) begin
      errors++; $display("FAIL bp_refill got=v%b id%0d %h exp=v1 id2 c2c20002", rsp_valid, rsp_id, rsp_data);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_edge_amounts();
    logic [31:0] din [5];
    logic [4:0]  ain [5];
    logic [1:0]  oin [5];
    logic [31:0] exp_d [5];
    din   = '{32'h0000_0001, 32'hDEAD_BEEF, 32'h8000_0000, 32'h7000_0000, 32'h8000_0000};
    ain   = '{5'd31,         5'd0,          5'd31,         5'd4,          5'd31};
    oin   = '{2'b10,         2'b00,         2'b00,         2'b01,         2'b01};
    exp_d = '{32'h8000_0000, 32'hDEAD_BEEF, 32'h0000_0001, 32'h0700_0000, 32'hFFFF_FFFF};
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_req(1, din[k], ain[k], oin[k]);
      req_valid = 4'b0010;
      tick();
      req_valid = '0;
      checks++; if (rsp_data !== exp_d[k] || rsp_id !== 2'd1 || rsp_err !== 1'b0) begin
        errors++; $display("FAIL edge[%0d] got=%h id%0d e%b exp=%h id1 e0", k, rsp_data, rsp_id, rsp_err, exp_d[k]);
      end
    end
    tick();
  endtask

  task automatic test_rotate();
    logic [31:0] exp_d;
    logic        exp_e;
`ifdef SHIFT_ARB_ROTATE_EN
    exp_d = 32'h1000_000F; exp_e = 1'b0;
`else
    exp_d = 32'h0000_00F1; exp_e = 1'b1;
`endif
    rsp_ready = 1'b1;
    set_req(2, 32'h0000_00F1, 5'd4, 2'b11);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rot_ready got=%b exp=0100", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (rsp_data !== exp_d || rsp_id !== 2'd2) begin errors++; $display("FAIL rot_data got=%h id%0d exp=%h id2", rsp_data, rsp_id, exp_d); end
    checks++; if (rsp_err !== exp_e) begin errors++; $display("FAIL rot_err got=%b exp=%b", rsp_err, exp_e); end
    // A following non-rotate result must clear the error flag.
    set_req(3, 32'h0000_00F1, 5'd4, 2'b00);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    checks++; if (rsp_err !== 1'b0 || rsp_data !== 32'h0000_000F) begin errors++; $display("FAIL rot_clear got=%h e%b exp=0000000f e0", rsp_data, rsp_err); end
    tick();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b1;
    set_req(1, 32'h1234_5678, 5'd0, 2'b00);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    rsp_ready = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin errors++; $display("FAIL rmid_setup got=v%b id%0d exp=v1 id1", rsp_valid, rsp_id); end
    rst_n = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h0000_0100 + i, 5'd0, 2'b00);
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rmid_ready got=%b exp=0000", req_ready); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b exp=0", rsp_valid); end
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rmid_grant got=%b exp=0001", req_ready); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 32'h0000_0100) begin
      errors++; $display("FAIL rmid_first got=v%b id%0d %h exp=v1 id0 00000100", rsp_valid, rsp_id, rsp_data);
    end
    req_valid = '0;
    tick();
  endtask

  initial begin
    req_data = '0;
    req_amt = '0;
    req_op = '0;
    test_reset();
    test_single_asr();
    test_round_robin();
    test_backpressure();
    test_edge_amounts();
    test_rotate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
